// File: rtl/turn_counter_pkg.sv
// Shared encodings for the turn counter: FSM states, operation codes and BCD digit limits.
package turn_counter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StUpdate = 2'd1,
        StAck    = 2'd2
    } state_e;

    typedef enum logic {
        OpInc = 1'b0,
        OpDec = 1'b1
    } op_e;

    localparam logic [3:0] DigitZero = 4'd0;
    localparam logic [3:0] DigitNine = 4'd9;

endpackage

// File: rtl/turn_counter_bcd_digit_step.sv
// Single BCD digit increment/decrement with carry (INC) or borrow (DEC) out.
module turn_counter_bcd_digit_step
    import turn_counter_pkg::*;
(
    input  logic       i_op,
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    always_comb begin
        o_digit = i_digit;
        o_carry = 1'b0;
        if (i_op == OpDec) begin
            if (i_digit == DigitZero) begin
                o_digit = DigitNine;
                o_carry = 1'b1;
            end else begin
                o_digit = i_digit - 4'd1;
            end
        end else begin
            if (i_digit == DigitNine) begin
                o_digit = DigitZero;
                o_carry = 1'b1;
            end else begin
                o_digit = i_digit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/turn_counter.sv
// Saturating turn counter with a level req/ack handshake; keeps a binary count and a
// BCD copy that is ripple-updated one digit per cycle after each change.
module turn_counter
    import turn_counter_pkg::*;
#(
    parameter int unsigned MAX_TURNS = 9999,
    parameter int unsigned TURN_W    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_move_req,
    input  logic              i_undo_req,
    input  logic              i_clear,
    output logic              o_move_ack,
    output logic              o_busy,
    output logic [TURN_W-1:0] o_turns,
    output logic [15:0]       o_bcd,
    output logic              o_saturated
);

    localparam logic [TURN_W-1:0] MaxTurns = TURN_W'(MAX_TURNS);

    state_e            r_state;
    state_e            w_state_next;
    op_e               r_op;
    op_e               w_op_next;
    op_e               w_req_op;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_next;
    logic [TURN_W-1:0] r_turns;
    logic [TURN_W-1:0] w_turns_next;
    logic [15:0]       r_bcd;
    logic [15:0]       w_bcd_next;
    logic              r_move_ack;
    logic              w_move_ack_next;
    logic              r_busy;
    logic              r_saturated;
    logic              w_any_req;
    logic              w_at_limit;
    logic [3:0]        w_digit;
    logic [3:0]        w_new_digit;
    logic              w_carry;

    assign w_any_req  = i_move_req | i_undo_req;
    assign w_req_op   = i_move_req ? OpInc : OpDec;
    assign w_at_limit = (w_req_op == OpInc) ? (r_turns == MaxTurns) : (r_turns == '0);
    assign w_digit    = r_bcd[{r_idx, 2'b00} +: 4];

    turn_counter_bcd_digit_step u_digit_step (
        .i_op    (r_op),
        .i_digit (w_digit),
        .o_digit (w_new_digit),
        .o_carry (w_carry)
    );

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_idx_next   = r_idx;
        w_turns_next = r_turns;
        w_bcd_next   = r_bcd;

        case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_op_next = w_req_op;
                    if (w_at_limit) begin
                        w_state_next = StAck;
                    end else begin
                        w_turns_next = (w_req_op == OpInc) ? r_turns + TURN_W'(1)
                                                           : r_turns - TURN_W'(1);
                        w_idx_next   = 2'd0;
                        w_state_next = StUpdate;
                    end
                end
            end
            StUpdate: begin
                w_bcd_next[{r_idx, 2'b00} +: 4] = w_new_digit;
                if (w_carry && (r_idx != 2'd3)) begin
                    w_idx_next = r_idx + 2'd1;
                end else begin
                    w_state_next = StAck;
                end
            end
            StAck: begin
                if (!w_any_req) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        if (i_clear) begin
            w_state_next = StIdle;
            w_idx_next   = 2'd0;
            w_turns_next = '0;
            w_bcd_next   = '0;
        end
    end

    // Ack is raised on the edge after ACK is entered and drops together with the return to IDLE.
    assign w_move_ack_next = (r_state == StAck) && (w_state_next == StAck);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_op        <= OpInc;
            r_idx       <= 2'd0;
            r_turns     <= '0;
            r_bcd       <= '0;
            r_move_ack  <= 1'b0;
            r_busy      <= 1'b0;
            r_saturated <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_op        <= w_op_next;
            r_idx       <= w_idx_next;
            r_turns     <= w_turns_next;
            r_bcd       <= w_bcd_next;
            r_move_ack  <= w_move_ack_next;
            r_busy      <= (w_state_next != StIdle);
            r_saturated <= (r_turns == MaxTurns);
        end
    end

    assign o_move_ack  = r_move_ack;
    assign o_busy      = r_busy;
    assign o_turns     = r_turns;
    assign o_bcd       = r_bcd;
    assign o_saturated = r_saturated;

endmodule
